// File: rtl/cache_fill_pkg.sv
// Shared definitions for the cache miss-fill arbiter.
//   state_t   : FSM encoding (IDLE, FILL)
//   ARB_FIXED : lowest requesting channel index wins
//   ARB_RR    : round-robin starting at the rotating pointer
//   blk_off_w : number of byte-offset bits inside one block
package cache_fill_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  function automatic int blk_off_w(input int words, input int data_w);
    return $clog2(words * (data_w / 8));
  endfunction

endpackage

// File: rtl/fill_arb_pick.sv
// Combinational winner select for the fill arbiter.
//   i_req      : per-channel request vector
//   i_mask     : channels excluded from this pick
//   i_rr_ptr   : first index examined in round-robin mode
//   i_mode     : 0 = fixed priority (index 0 highest), 1 = round-robin
//   o_grant_oh : one-hot winner
//   o_idx      : winner index
//   o_vld      : at least one eligible request
module fill_arb_pick #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = 1
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [NUM_CH-1:0] i_mask,
  input  logic [IDX_W-1:0]  i_rr_ptr,
  input  logic              i_mode,
  output logic [NUM_CH-1:0] o_grant_oh,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_vld
);

  logic [NUM_CH-1:0] w_elig;

  assign w_elig = i_req & ~i_mask;

  // Walk the channels starting at 0 (fixed) or at the pointer (round-robin),
  // wrapping once; the first eligible channel found wins.
  always_comb begin
    int j;
    j          = 0;
    o_grant_oh = '0;
    o_idx      = '0;
    o_vld      = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      j = i_mode ? (int'(i_rr_ptr) + k) : k;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!o_vld && w_elig[j]) begin
        o_vld         = 1'b1;
        o_idx         = IDX_W'(j);
        o_grant_oh[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_fill_arbiter.sv
// Miss-fill controller shared by NUM_CH caches. Picks one pending miss,
// reads its block word by word from a pipelined memory (up to MAX_OUTST
// reads in flight), streams each returned word into the granted cache and
// writes that cache's metadata with the last word. A new fill can be
// granted on the last word of the current one, so fills run back to back.
//   clk, rst_n              : clock, asynchronous active-low reset
//   miss_req / miss_addr    : per-channel miss and its byte address
//   fill_data / fill_addr   : returned word and its byte address
//   fill_data_we/meta_we    : one-hot data / metadata write enables
//   mem_en / mem_addr       : memory read issue
//   mem_data / mem_vld      : memory return, in issue order
//   stall, idle             : pipeline stall, high while in IDLE
//   dbg_state               : current FSM state
module cache_fill_arbiter
  import cache_fill_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int WORDS_PER_BLK = 8,
  parameter int MAX_OUTST     = 4,
  parameter int ARB_MODE      = ARB_FIXED
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        miss_req,
  input  logic [NUM_CH*ADDR_W-1:0] miss_addr,
  output logic [DATA_W-1:0]        fill_data,
  output logic [ADDR_W-1:0]        fill_addr,
  output logic [NUM_CH-1:0]        fill_data_we,
  output logic [NUM_CH-1:0]        fill_meta_we,
  output logic                     mem_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_data,
  input  logic                     mem_vld,
  output logic                     stall,
  output logic                     idle,
  output state_t                   dbg_state
);

  localparam int CNT_W = $clog2(WORDS_PER_BLK) + 1;
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int OFF_W = blk_off_w(WORDS_PER_BLK, DATA_W);

  localparam logic [ADDR_W-1:0] STRIDE_A  = ADDR_W'(DATA_W / 8);
  localparam logic [ADDR_W-1:0] BLK_MASK  = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(WORDS_PER_BLK);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WORDS_PER_BLK - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
  localparam logic [31:0]       MAX_OUT_U = 32'(MAX_OUTST);

  // Grant is held one-hot; it drives the write enables and the
  // back-to-back mask directly. Reset value is all zero.
  state_t              r_state,      w_state_nxt;
  logic [NUM_CH-1:0]   r_grant_oh,   w_grant_oh_nxt;
  logic [ADDR_W-1:0]   r_base,       w_base_nxt;
  logic [CNT_W-1:0]    r_issue_cnt,  w_issue_cnt_nxt;
  logic [CNT_W-1:0]    r_recv_cnt,   w_recv_cnt_nxt;
  logic [IDX_W-1:0]    r_rr_ptr,     w_rr_ptr_nxt;

  logic                w_in_fill;
  logic [CNT_W-1:0]    w_outst;
  logic                w_issue;
  logic                w_recv;
  logic                w_last;
  logic [NUM_CH-1:0]   w_mask;
  logic [NUM_CH-1:0]   w_pick_oh;
  logic [IDX_W-1:0]    w_pick_idx;
  logic                w_pick_vld;
  logic [ADDR_W-1:0]   w_pick_addr;

  assign w_in_fill = (r_state == ST_FILL);
  assign w_outst   = r_issue_cnt - r_recv_cnt;
  assign w_issue   = w_in_fill && (r_issue_cnt < CNT_FULL) && (32'(w_outst) < MAX_OUT_U);
  // Returns beyond what was issued (including anything arriving in IDLE)
  // are stray and dropped.
  assign w_recv    = w_in_fill && mem_vld && (r_recv_cnt < r_issue_cnt);
  assign w_last    = w_recv && (r_recv_cnt == CNT_LAST);

  // Only the last-word re-arbitration excludes the channel just served.
  assign w_mask      = w_in_fill ? r_grant_oh : '0;
  assign w_pick_addr = miss_addr[int'(w_pick_idx)*ADDR_W +: ADDR_W];

  fill_arb_pick #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_pick (
    .i_req      (miss_req),
    .i_mask     (w_mask),
    .i_rr_ptr   (r_rr_ptr),
    .i_mode     (ARB_MODE == ARB_RR),
    .o_grant_oh (w_pick_oh),
    .o_idx      (w_pick_idx),
    .o_vld      (w_pick_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_grant_oh  <= '0;
      r_base      <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_rr_ptr    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant_oh  <= w_grant_oh_nxt;
      r_base      <= w_base_nxt;
      r_issue_cnt <= w_issue_cnt_nxt;
      r_recv_cnt  <= w_recv_cnt_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
    end
  end

  always_comb begin
    logic take;
    take            = 1'b0;
    w_state_nxt     = r_state;
    w_grant_oh_nxt  = r_grant_oh;
    w_base_nxt      = r_base;
    w_issue_cnt_nxt = r_issue_cnt;
    w_recv_cnt_nxt  = r_recv_cnt;
    w_rr_ptr_nxt    = r_rr_ptr;
    unique case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) begin
          take        = 1'b1;
          w_state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        if (w_issue) w_issue_cnt_nxt = r_issue_cnt + CNT_ONE;
        if (w_recv)  w_recv_cnt_nxt  = r_recv_cnt + CNT_ONE;
        if (w_last) begin
          w_issue_cnt_nxt = '0;
          w_recv_cnt_nxt  = '0;
          if (w_pick_vld) take = 1'b1;
          else            w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (take) begin
      w_grant_oh_nxt = w_pick_oh;
      w_base_nxt     = w_pick_addr & BLK_MASK;
      w_rr_ptr_nxt   = (int'(w_pick_idx) == NUM_CH - 1) ? '0 : (w_pick_idx + IDX_ONE);
    end
  end

  assign mem_en       = w_issue;
  assign mem_addr     = w_issue ? (r_base + ADDR_W'(r_issue_cnt) * STRIDE_A) : r_base;
  assign fill_data    = w_recv ? mem_data : '0;
  assign fill_addr    = w_recv ? (r_base + ADDR_W'(r_recv_cnt) * STRIDE_A) : '0;
  assign fill_data_we = w_recv ? r_grant_oh : '0;
  assign fill_meta_we = w_last ? r_grant_oh : '0;
  assign idle         = !w_in_fill;
  assign stall        = w_in_fill || (|miss_req);
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter. Three instances:
//   u_dut_a : default build (fixed priority, 2 channels, 4 outstanding)
//   u_dut_b : 3 channels, round-robin
//   u_dut_c : 1 outstanding read
// Each has a memory model returning (addr ^ 16'h5A5A) a set latency after
// the read issue. Handshake: mem_en is a one-cycle issue strobe, mem_vld a
// one-cycle return strobe, returns arrive in issue order, no backpressure.
module tb_cache_fill_arbiter;
  import cache_fill_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  typedef struct {
    int          due;
    logic [15:0] data;
  } mem_rsp_t;

  // ---------------- instance A: defaults ----------------
  logic [1:0]  miss_req_a = '0;
  logic [31:0] miss_addr_a = '0;
  logic [15:0] fill_data_a, fill_addr_a, mem_addr_a;
  logic [15:0] mem_data_a = '0;
  logic [1:0]  fill_data_we_a, fill_meta_we_a;
  logic        mem_en_a, stall_a, idle_a;
  logic        mem_vld_a = 1'b0;
  state_t      dbg_a;

  cache_fill_arbiter u_dut_a (
    .clk(clk), .rst_n(rst_n), .miss_req(miss_req_a), .miss_addr(miss_addr_a),
    .fill_data(fill_data_a), .fill_addr(fill_addr_a), .fill_data_we(fill_data_we_a),
    .fill_meta_we(fill_meta_we_a), .mem_en(mem_en_a), .mem_addr(mem_addr_a),
    .mem_data(mem_data_a), .mem_vld(mem_vld_a), .stall(stall_a), .idle(idle_a),
    .dbg_state(dbg_a)
  );

  // ---------------- instance B: 3 channels, round-robin ----------------
  logic [2:0]  miss_req_b = '0;
  logic [47:0] miss_addr_b = '0;
  logic [15:0] fill_data_b, fill_addr_b, mem_addr_b;
  logic [15:0] mem_data_b = '0;
  logic [2:0]  fill_data_we_b, fill_meta_we_b;
  logic        mem_en_b, stall_b, idle_b;
  logic        mem_vld_b = 1'b0;
  state_t      dbg_b;

  cache_fill_arbiter #(.NUM_CH(3), .ARB_MODE(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .miss_req(miss_req_b), .miss_addr(miss_addr_b),
    .fill_data(fill_data_b), .fill_addr(fill_addr_b), .fill_data_we(fill_data_we_b),
    .fill_meta_we(fill_meta_we_b), .mem_en(mem_en_b), .mem_addr(mem_addr_b),
    .mem_data(mem_data_b), .mem_vld(mem_vld_b), .stall(stall_b), .idle(idle_b),
    .dbg_state(dbg_b)
  );

  // ---------------- instance C: one outstanding read ----------------
  logic [1:0]  miss_req_c = '0;
  logic [31:0] miss_addr_c = '0;
  logic [15:0] fill_data_c, fill_addr_c, mem_addr_c;
  logic [15:0] mem_data_c = '0;
  logic [1:0]  fill_data_we_c, fill_meta_we_c;
  logic        mem_en_c, stall_c, idle_c;
  logic        mem_vld_c = 1'b0;
  state_t      dbg_c;

  cache_fill_arbiter #(.MAX_OUTST(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .miss_req(miss_req_c), .miss_addr(miss_addr_c),
    .fill_data(fill_data_c), .fill_addr(fill_addr_c), .fill_data_we(fill_data_we_c),
    .fill_meta_we(fill_meta_we_c), .mem_en(mem_en_c), .mem_addr(mem_addr_c),
    .mem_data(mem_data_c), .mem_vld(mem_vld_c), .stall(stall_c), .idle(idle_c),
    .dbg_state(dbg_c)
  );

  // ---------------- memory models (drive at negedge) ----------------
  int lat_a = 4, lat_b = 2, lat_c = 3;
  logic stray_a = 1'b0;
  mem_rsp_t pend_a[$], pend_b[$], pend_c[$];

  always @(negedge clk) begin
    if (mem_en_a) pend_a.push_back('{cyc + lat_a, mem_word(mem_addr_a)});
    if (pend_a.size() != 0 && pend_a[0].due == cyc) begin
      mem_vld_a  = 1'b1;
      mem_data_a = pend_a[0].data;
      void'(pend_a.pop_front());
    end else begin
      mem_vld_a  = stray_a;
      mem_data_a = 16'hDEAD;
    end
  end

  always @(negedge clk) begin
    if (mem_en_b) pend_b.push_back('{cyc + lat_b, mem_word(mem_addr_b)});
    if (pend_b.size() != 0 && pend_b[0].due == cyc) begin
      mem_vld_b  = 1'b1;
      mem_data_b = pend_b[0].data;
      void'(pend_b.pop_front());
    end else begin
      mem_vld_b  = 1'b0;
      mem_data_b = 16'hDEAD;
    end
  end

  always @(negedge clk) begin
    if (mem_en_c) pend_c.push_back('{cyc + lat_c, mem_word(mem_addr_c)});
    if (pend_c.size() != 0 && pend_c[0].due == cyc) begin
      mem_vld_c  = 1'b1;
      mem_data_c = pend_c[0].data;
      void'(pend_c.pop_front());
    end else begin
      mem_vld_c  = 1'b0;
      mem_data_c = 16'hDEAD;
    end
  end

  // ---------------- scoreboard A (sample at negedge + 3) ----------------
  // fill record: {data_we[1:0], meta_we[1:0], addr[15:0], data[15:0]}
  logic [15:0] exp_mem_a[$];
  logic [35:0] exp_fill_a[$];
  int  iss_a = 0, ret_a = 0, we_cnt_a = 0, meta_cnt_a = 0;
  int  first_we_a = -1, mem8010_cyc = -1;
  int  meta_cyc_a[$];
  bit  watch_a = 0, gap_a = 0;

  always @(negedge clk) begin
    logic [35:0] e;
    #3;
    if (mem_en_a) begin
      if (exp_mem_a.size() != 0) check("mem_addr_a", mem_addr_a, exp_mem_a.pop_front());
      else                       check("mem_en_unexp_a", mem_en_a, 0);
      check("outst_a", (iss_a - ret_a) < 4, 1);
      if (mem_addr_a == 16'h8010 && mem8010_cyc < 0) mem8010_cyc = cyc;
      iss_a++;
    end
    if (fill_data_we_a != 0 || fill_meta_we_a != 0) begin
      if (exp_fill_a.size() != 0) begin
        e = exp_fill_a.pop_front();
        check("fill_we_a",   fill_data_we_a, e[35:34]);
        check("fill_meta_a", fill_meta_we_a, e[33:32]);
        check("fill_addr_a", fill_addr_a,    e[31:16]);
        check("fill_data_a", fill_data_a,    e[15:0]);
      end else begin
        check("fill_unexp_a", {fill_data_we_a, fill_meta_we_a}, 0);
      end
      if (fill_data_we_a != 0) begin
        we_cnt_a++;
        ret_a++;
        if (first_we_a < 0) first_we_a = cyc;
      end
      if (fill_meta_we_a != 0) begin
        meta_cnt_a++;
        meta_cyc_a.push_back(cyc);
      end
    end
    if (watch_a && (idle_a || !stall_a)) gap_a = 1;
  end

  // ---------------- scoreboard B ----------------
  logic [2:0] exp_gnt_b[$];
  int meta_cnt_b = 0;
  bit watch_b = 0, gap_b = 0;

  always @(negedge clk) begin
    logic [2:0] e;
    #3;
    if (fill_meta_we_b != 0) begin
      e = (exp_gnt_b.size() != 0) ? exp_gnt_b.pop_front() : 3'b000;
      check("gnt_order_b", fill_meta_we_b, e);
      check("gnt_we_b", fill_data_we_b, e);
      meta_cnt_b++;
    end
    if (watch_b && idle_b) gap_b = 1;
  end

  // ---------------- scoreboard C ----------------
  int iss_c = 0, ret_c = 0, we_cnt_c = 0, meta_cnt_c = 0, meta_cyc_c = -1;

  always @(negedge clk) begin
    #3;
    if (mem_en_c) begin
      check("outst_c", iss_c - ret_c, 0);
      iss_c++;
    end
    if (fill_data_we_c != 0) begin
      ret_c++;
      we_cnt_c++;
    end
    if (fill_meta_we_c != 0) begin
      meta_cnt_c++;
      meta_cyc_c = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_blk_a(input logic [15:0] base, input logic [1:0] ch);
    logic [15:0] a;
    for (int k = 0; k < 8; k++) begin
      a = base + 16'(k * 2);
      exp_mem_a.push_back(a);
      exp_fill_a.push_back({ch, (k == 7) ? ch : 2'b00, a, mem_word(a)});
    end
  endtask

  task automatic step();
    @(negedge clk);
    #4;
  endtask

  task automatic wait_meta_a(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (meta_cnt_a >= target) break;
    end
    check("wait_meta_a", meta_cnt_a, target);
    miss_req_a = '0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int g, tgt, we_before, meta_before;

    // reset state
    step();
    check("rst_idle",  idle_a, 1);
    check("rst_state", dbg_a, ST_IDLE);
    check("rst_mem_en", mem_en_a, 0);
    check("rst_fill_data", fill_data_a, 0);
    check("rst_fill_addr", fill_addr_a, 0);
    check("rst_we", {fill_data_we_a, fill_meta_we_a}, 0);
    check("rst_stall_lo", stall_a, 0);
    miss_req_a = 2'b01;
    #1;
    check("rst_stall_hi", stall_a, 1);
    miss_req_a = 2'b00;
    step();
    rst_n = 1'b1;
    step();

    // 1: single fill, latency 4, up to 4 outstanding
    lat_a = 4;
    load_blk_a(16'h1230, 2'b01);
    miss_addr_a[15:0] = 16'h1236;
    miss_req_a = 2'b01;
    step();
    miss_req_a = 2'b00;
    check("t1_stall", stall_a, 1);
    check("t1_idle", idle_a, 0);
    check("t1_state", dbg_a, ST_FILL);
    wait_meta_a(1, 80);
    step();
    check("t1_idle_after", idle_a, 1);
    check("t1_stall_after", stall_a, 0);
    check("t1_mem_left", exp_mem_a.size(), 0);
    check("t1_fill_left", exp_fill_a.size(), 0);
    check("t1_words", we_cnt_a, 8);

    // 2: both channels, fixed priority, back-to-back, latency 3
    lat_a = 3;
    first_we_a = -1;
    mem8010_cyc = -1;
    meta_cyc_a.delete();
    load_blk_a(16'h0040, 2'b01);
    load_blk_a(16'h8010, 2'b10);
    tgt = meta_cnt_a + 2;
    miss_addr_a = {16'h8010, 16'h0040};
    miss_req_a = 2'b11;
    g = cyc;
    step();
    miss_req_a = 2'b10;
    gap_a = 0;
    watch_a = 1;
    wait_meta_a(tgt, 120);
    watch_a = 0;
    check("t2_no_gap", gap_a, 0);
    check("t2_first_we_lat", first_we_a - g, 4);
    check("t2_ch0_span", meta_cyc_a[0] - first_we_a, 7);
    check("t2_b2b_issue", mem8010_cyc - meta_cyc_a[0], 1);
    check("t2_fill_left", exp_fill_a.size(), 0);
    step();
    check("t2_idle_after", idle_a, 1);

    // 4: block at top of address space, then a stray return in IDLE
    lat_a = 2;
    load_blk_a(16'hFFF0, 2'b10);
    tgt = meta_cnt_a + 1;
    miss_addr_a[31:16] = 16'hFFF8;
    miss_req_a = 2'b10;
    step();
    miss_req_a = 2'b00;
    wait_meta_a(tgt, 80);
    check("t4_mem_left", exp_mem_a.size(), 0);
    step();
    stray_a = 1'b1;
    @(negedge clk);
    #3;
    check("t4_stray_we", fill_data_we_a, 0);
    check("t4_stray_meta", fill_meta_we_a, 0);
    check("t4_stray_data", fill_data_a, 0);
    check("t4_stray_idle", idle_a, 1);
    #1;
    stray_a = 1'b0;
    step();

    // 6: reset in the middle of a fill
    lat_a = 4;
    load_blk_a(16'h2000, 2'b01);
    we_before = we_cnt_a;
    miss_addr_a[15:0] = 16'h2000;
    miss_req_a = 2'b01;
    step();
    miss_req_a = 2'b00;
    for (int i = 0; i < 40; i++) begin
      if (we_cnt_a >= we_before + 3) break;
      step();
    end
    check("t6_three_words", we_cnt_a - we_before, 3);
    rst_n = 1'b0;
    #1;
    check("t6_rst_mem_en", mem_en_a, 0);
    check("t6_rst_we", {fill_data_we_a, fill_meta_we_a}, 0);
    check("t6_rst_data", fill_data_a, 0);
    check("t6_rst_idle", idle_a, 1);
    check("t6_rst_stall", stall_a, 0);
    exp_mem_a.delete();
    exp_fill_a.delete();
    iss_a = 0;
    ret_a = 0;
    we_before = we_cnt_a;
    meta_before = meta_cnt_a;
    step();
    step();
    rst_n = 1'b1;
    repeat (10) step();
    check("t6_no_late_we", we_cnt_a, we_before);
    check("t6_no_meta", meta_cnt_a, meta_before);
    check("t6_idle", idle_a, 1);

    // 3: round-robin over three continuously requesting channels
    exp_gnt_b = '{3'b001, 3'b010, 3'b100, 3'b001};
    miss_addr_b = {16'h3000, 16'h2000, 16'h1000};
    miss_req_b = 3'b111;
    step();
    gap_b = 0;
    watch_b = 1;
    for (int i = 0; i < 200; i++) begin
      if (meta_cnt_b >= 4) break;
      step();
    end
    miss_req_b = '0;
    watch_b = 0;
    check("t3_fills", meta_cnt_b, 4);
    check("t3_no_gap", gap_b, 0);
    check("t3_order_left", exp_gnt_b.size(), 0);
    step();

    // 5: one outstanding read, latency 3
    miss_addr_c[15:0] = 16'h0100;
    miss_req_c = 2'b01;
    g = cyc;
    step();
    miss_req_c = 2'b00;
    for (int i = 0; i < 100; i++) begin
      if (meta_cnt_c >= 1) break;
      step();
    end
    check("t5_fills", meta_cnt_c, 1);
    check("t5_words", we_cnt_c, 8);
    check("t5_duration", meta_cyc_c - g, 32);
    step();
    check("t5_idle", idle_c, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
